ctrl_pipe_hazard: RTL and testbench

- Consumer end of the decoded-control interface: takes the per-instruction control word produced in ID and carries it through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Drives stage-local control for the EX, MEM and WB datapath slices.
- Contains load-use hazard detection (stall plus bubble), branch/jump flush, and EX-stage forwarding selects.
- Sits between the ID-stage decoder and the pipelined datapath of the 5-stage MIPS core.

---
 rtl/ctrl_pkg.sv | 57 +++++
 rtl/ctrl_pipe_hazard_fwd.sv | 20 ++
 rtl/ctrl_pipe_hazard.sv | 158 +++++++++++++++
 tb/tb_ctrl_pipe_hazard.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared control-path definitions for the 5-stage MIPS pipeline: opcodes,
// widths, the decoded control word and forwarding select encodings.
package ctrl_pkg;

   localparam int unsigned REG_W   = 5;
   localparam int unsigned ALUOP_W = 3;
   localparam int unsigned OPC_W   = 6;
   localparam int unsigned FWD_W   = 2;

   localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OPC_W-1:0] OP_J     = 6'h02;
   localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
   localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OPC_W-1:0] OP_SLTI  = 6'h0A;
   localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0C;
   localparam logic [OPC_W-1:0] OP_ORI   = 6'h0D;
   localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
   localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

   typedef logic [REG_W-1:0] reg_idx_t;
   typedef logic [FWD_W-1:0] fwd_sel_t;

   localparam fwd_sel_t FWD_RF  = 2'b00;
   localparam fwd_sel_t FWD_MEM = 2'b10;
   localparam fwd_sel_t FWD_WB  = 2'b01;

   // Control word carried from ID into ID/EX; jump is resolved in ID and not stored.
   typedef struct packed {
      logic [ALUOP_W-1:0] alu_op;
      logic               reg_dest;
      logic               reg_write;
      logic               alu_src;
      logic               mem_read;
      logic               mem_write;
      logic               mem_to_reg;
      logic               branch;
   } ctrl_word_t;

   localparam ctrl_word_t BUBBLE = '0;

   // Youngest producer wins; register 0 is hard-wired and never forwarded.
   function automatic fwd_sel_t fwd_select(input logic     mem_rw,
                                           input reg_idx_t mem_dst,
                                           input logic     wb_rw,
                                           input reg_idx_t wb_dst,
                                           input reg_idx_t src);
      fwd_sel_t sel;
      sel = FWD_RF;
      if (mem_rw && (mem_dst != '0) && (mem_dst == src))
         sel = FWD_MEM;
      else if (wb_rw && (wb_dst != '0) && (wb_dst == src))
         sel = FWD_WB;
      return sel;
   endfunction

endpackage

// File: rtl/ctrl_pipe_hazard_fwd.sv
// EX-stage operand forwarding selects, purely combinational.
module fwd_unit
   import ctrl_pkg::*;
(
   input  logic     i_mem_reg_write,
   input  reg_idx_t i_mem_dst,
   input  logic     i_wb_reg_write,
   input  reg_idx_t i_wb_dst,
   input  reg_idx_t i_ex_rs,
   input  reg_idx_t i_ex_rt,
   output fwd_sel_t o_fwd_a,
   output fwd_sel_t o_fwd_b
);

   always_comb begin
      o_fwd_a = fwd_select(i_mem_reg_write, i_mem_dst, i_wb_reg_write, i_wb_dst, i_ex_rs);
      o_fwd_b = fwd_select(i_mem_reg_write, i_mem_dst, i_wb_reg_write, i_wb_dst, i_ex_rt);
   end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// Control pipeline ID/EX -> EX/MEM -> MEM/WB with load-use stall, branch/jump
// flush and forwarding selects for the 5-stage MIPS core.
module ctrl_pipe_hazard
   import ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [ALUOP_W-1:0] id_alu_op,
   input  logic               id_reg_dest,
   input  logic               id_reg_write,
   input  logic               id_alu_src,
   input  logic               id_mem_read,
   input  logic               id_mem_write,
   input  logic               id_mem_to_reg,
   input  logic               id_branch,
   input  logic               id_jump,
   input  logic [REG_W-1:0]   id_rs,
   input  logic [REG_W-1:0]   id_rt,
   input  logic [REG_W-1:0]   id_rd,
   input  logic               ex_cond,
   output logic [ALUOP_W-1:0] ex_alu_op,
   output logic               ex_reg_dest,
   output logic               ex_alu_src,
   output logic [REG_W-1:0]   ex_rs,
   output logic [REG_W-1:0]   ex_rt,
   output logic [1:0]         fwd_a,
   output logic [1:0]         fwd_b,
   output logic               mem_mem_read,
   output logic               mem_mem_write,
   output logic               wb_reg_write,
   output logic               wb_mem_to_reg,
   output logic [REG_W-1:0]   wb_dst,
   output logic               pc_write,
   output logic               ifid_write,
   output logic               ifid_flush
);

   ctrl_word_t r_ex_ctrl;
   reg_idx_t   r_ex_rs;
   reg_idx_t   r_ex_rt;
   reg_idx_t   r_ex_dst;

   logic       r_mem_mem_read;
   logic       r_mem_mem_write;
   logic       r_mem_reg_write;
   logic       r_mem_mem_to_reg;
   reg_idx_t   r_mem_dst;

   logic       r_wb_reg_write;
   logic       r_wb_mem_to_reg;
   reg_idx_t   r_wb_dst;

   logic       w_stall;
   logic       w_taken;
   logic       w_bubble;
   ctrl_word_t w_id_ctrl;
   reg_idx_t   w_id_rs;
   reg_idx_t   w_id_rt;
   reg_idx_t   w_id_dst;

   assign w_stall = r_ex_ctrl.mem_read && (r_ex_dst != '0) &&
                    ((r_ex_dst == id_rs) || (r_ex_dst == id_rt));
   assign w_taken = r_ex_ctrl.branch && ex_cond;

   // Hazard priority: reset > taken branch > load-use stall > jump in ID.
   always_comb begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      w_bubble   = 1'b0;
      if (!rst) begin
         if (w_taken) begin
            ifid_flush = 1'b1;
            w_bubble   = 1'b1;
         end else if (w_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            w_bubble   = 1'b1;
         end else if (id_jump) begin
            ifid_flush = 1'b1;
         end
      end
   end

   // ID-side payload for ID/EX; decoder don't-cares on a jump are masked here.
   always_comb begin
      w_id_ctrl = BUBBLE;
      w_id_rs   = '0;
      w_id_rt   = '0;
      w_id_dst  = '0;
      if (!w_bubble) begin
         w_id_ctrl.alu_op     = id_alu_op;
         w_id_ctrl.reg_dest   = id_reg_dest;
         w_id_ctrl.reg_write  = id_reg_write;
         w_id_ctrl.alu_src    = id_alu_src;
         w_id_ctrl.mem_read   = id_mem_read & ~id_jump;
         w_id_ctrl.mem_write  = id_mem_write;
         w_id_ctrl.mem_to_reg = id_mem_to_reg;
         w_id_ctrl.branch     = id_branch & ~id_jump;
         w_id_rs              = id_rs;
         w_id_rt              = id_rt;
         w_id_dst             = id_reg_dest ? id_rd : id_rt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex_ctrl        <= BUBBLE;
         r_ex_rs          <= '0;
         r_ex_rt          <= '0;
         r_ex_dst         <= '0;
         r_mem_mem_read   <= 1'b0;
         r_mem_mem_write  <= 1'b0;
         r_mem_reg_write  <= 1'b0;
         r_mem_mem_to_reg <= 1'b0;
         r_mem_dst        <= '0;
         r_wb_reg_write   <= 1'b0;
         r_wb_mem_to_reg  <= 1'b0;
         r_wb_dst         <= '0;
      end else begin
         r_ex_ctrl        <= w_id_ctrl;
         r_ex_rs          <= w_id_rs;
         r_ex_rt          <= w_id_rt;
         r_ex_dst         <= w_id_dst;
         r_mem_mem_read   <= r_ex_ctrl.mem_read;
         r_mem_mem_write  <= r_ex_ctrl.mem_write;
         r_mem_reg_write  <= r_ex_ctrl.reg_write;
         r_mem_mem_to_reg <= r_ex_ctrl.mem_to_reg;
         r_mem_dst        <= r_ex_dst;
         r_wb_reg_write   <= r_mem_reg_write;
         r_wb_mem_to_reg  <= r_mem_mem_to_reg;
         r_wb_dst         <= r_mem_dst;
      end
   end

   assign ex_alu_op     = r_ex_ctrl.alu_op;
   assign ex_reg_dest   = r_ex_ctrl.reg_dest;
   assign ex_alu_src    = r_ex_ctrl.alu_src;
   assign ex_rs         = r_ex_rs;
   assign ex_rt         = r_ex_rt;
   assign mem_mem_read  = r_mem_mem_read;
   assign mem_mem_write = r_mem_mem_write;
   assign wb_reg_write  = r_wb_reg_write;
   assign wb_mem_to_reg = r_wb_mem_to_reg;
   assign wb_dst        = r_wb_dst;

   fwd_unit u_fwd (
      .i_mem_reg_write (r_mem_reg_write),
      .i_mem_dst       (r_mem_dst),
      .i_wb_reg_write  (r_wb_reg_write),
      .i_wb_dst        (r_wb_dst),
      .i_ex_rs         (r_ex_rs),
      .i_ex_rt         (r_ex_rt),
      .o_fwd_a         (fwd_a),
      .o_fwd_b         (fwd_b)
   );

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Bench for ctrl_pipe_hazard: directed hazard scenarios plus randomized
// instruction streams against an instruction-queue reference model.
module tb_ctrl_pipe_hazard;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] id_alu_op;
   logic       id_reg_dest, id_reg_write, id_alu_src, id_mem_read;
   logic       id_mem_write, id_mem_to_reg, id_branch, id_jump;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       ex_cond;
   logic [2:0] ex_alu_op;
   logic       ex_reg_dest, ex_alu_src;
   logic [4:0] ex_rs, ex_rt;
   logic [1:0] fwd_a, fwd_b;
   logic       mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg;
   logic [4:0] wb_dst;
   logic       pc_write, ifid_write, ifid_flush;

   always #5 clk = ~clk;

   ctrl_pipe_hazard dut (
      .clk(clk), .rst(rst),
      .id_alu_op(id_alu_op), .id_reg_dest(id_reg_dest), .id_reg_write(id_reg_write),
      .id_alu_src(id_alu_src), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch), .id_jump(id_jump),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_cond(ex_cond),
      .ex_alu_op(ex_alu_op), .ex_reg_dest(ex_reg_dest), .ex_alu_src(ex_alu_src),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
      .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_dst(wb_dst),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush)
   );

   // One in-flight instruction; pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB.
   typedef struct {
      logic [2:0] alu_op;
      logic       reg_dest, reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch;
      logic [4:0] rs, rt, dst;
   } ins_t;

   ins_t pipe [3];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic ins_t nop_ins();
      ins_t n;
      n = '{default: '0};
      return n;
   endfunction

   function automatic ins_t id_ins();
      ins_t n;
      n.alu_op     = id_alu_op;
      n.reg_dest   = id_reg_dest;
      n.reg_write  = id_reg_write;
      n.alu_src    = id_alu_src;
      n.mem_read   = id_mem_read && !id_jump;
      n.mem_write  = id_mem_write;
      n.mem_to_reg = id_mem_to_reg;
      n.branch     = id_branch && !id_jump;
      n.rs         = id_rs;
      n.rt         = id_rt;
      n.dst        = id_reg_dest ? id_rd : id_rt;
      return n;
   endfunction

   function automatic logic [1:0] ref_fwd(input logic [4:0] src);
      if (pipe[1].reg_write && pipe[1].dst != 0 && pipe[1].dst == src) return 2'b10;
      if (pipe[2].reg_write && pipe[2].dst != 0 && pipe[2].dst == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic ref_stall();
      return !rst && pipe[0].mem_read && pipe[0].dst != 0 &&
             (pipe[0].dst == id_rs || pipe[0].dst == id_rt);
   endfunction

   function automatic logic ref_taken();
      return !rst && pipe[0].branch && ex_cond;
   endfunction

   function automatic logic [30:0] exp_vec();
      logic t, s, hold, fl;
      t    = ref_taken();
      s    = ref_stall();
      hold = !t && s;
      fl   = !rst && (t || (!s && id_jump));
      return {pipe[0].alu_op, pipe[0].reg_dest, pipe[0].alu_src, pipe[0].rs, pipe[0].rt,
              ref_fwd(pipe[0].rs), ref_fwd(pipe[0].rt), pipe[1].mem_read, pipe[1].mem_write,
              pipe[2].reg_write, pipe[2].mem_to_reg, pipe[2].dst, !hold, !hold, fl};
   endfunction

   function automatic logic [30:0] obs_vec();
      return {ex_alu_op, ex_reg_dest, ex_alu_src, ex_rs, ex_rt, fwd_a, fwd_b,
              mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg, wb_dst,
              pc_write, ifid_write, ifid_flush};
   endfunction

   // Advance one clock, updating the model with the decision made on current inputs.
   task automatic tick();
      ins_t nx;
      nx = (ref_taken() || ref_stall()) ? nop_ins() : id_ins();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 3; i++) pipe[i] = nop_ins();
      end else begin
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = nx;
      end
      #1;
   endtask

   task automatic set_id(input logic [2:0] op, input logic rdst, rw, asrc, mr, mw, m2r, br, jp,
                         input logic [4:0] rs, rt, rd);
      id_alu_op = op;  id_reg_dest = rdst; id_reg_write = rw; id_alu_src = asrc;
      id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r; id_branch = br;
      id_jump = jp; id_rs = rs; id_rt = rt; id_rd = rd;
   endtask

   task automatic i_nop();                        set_id(3'd0, 0,0,0,0,0,0,0,0, 5'd0, 5'd0, 5'd0); endtask
   task automatic i_lw(input logic [4:0] rt, rs); set_id(3'd0, 0,1,1,1,0,1,0,0, rs, rt, 5'd0);    endtask
   task automatic i_add(input logic [4:0] rd, rs, rt); set_id(3'd2, 1,1,0,0,0,0,0,0, rs, rt, rd); endtask
   task automatic i_beq(input logic [4:0] rs, rt); set_id(3'd1, 0,0,0,0,0,0,1,0, rs, rt, 5'd0);   endtask
   // Jump with the decoder's don't-care branch/mem_read bits deliberately set.
   task automatic i_j(input logic [4:0] rs, rt);   set_id(3'd0, 0,0,0,1,0,0,1,1, rs, rt, 5'd0);   endtask

   task automatic drain();
      i_nop(); ex_cond = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      i_j(5'd1, 5'd2);
      @(posedge clk); #1;
      n_cmp++; if (obs_vec() !== 31'h6) begin n_bad++; $display("FAIL rst_hold: got %h want %h", obs_vec(), 31'h6); end
      @(posedge clk); #1;
      rst = 1'b0;
      i_add(5'd1, 5'd2, 5'd3); #1; tick();
      i_nop(); tick(); tick();
      n_cmp++; if ({wb_reg_write, wb_dst} !== {1'b1, 5'd1}) begin n_bad++; $display("FAIL rst_pre_wb: got %b/%0d want 1/1", wb_reg_write, wb_dst); end
      rst = 1'b1;
      for (int i = 0; i < 3; i++) pipe[i] = nop_ins();
      #1;
      n_cmp++; if (obs_vec() !== 31'h6) begin n_bad++; $display("FAIL rst_async: got %h want %h", obs_vec(), 31'h6); end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (obs_vec() !== exp_vec() || wb_reg_write !== 1'b0) begin n_bad++; $display("FAIL rst_drain%0d: got %h want %h", i, obs_vec(), exp_vec()); end
         tick();
      end
   endtask

   task automatic test_load_use();
      drain();
      i_lw(5'd2, 5'd0); #1; tick();
      i_add(5'd4, 5'd2, 5'd3); #1;
      n_cmp++; if ({pc_write, ifid_write, ifid_flush} !== 3'b000) begin n_bad++; $display("FAIL lu_stall: got %b want 000", {pc_write, ifid_write, ifid_flush}); end
      tick(); #1;
      n_cmp++; if ({ex_alu_op, ex_reg_dest, ex_alu_src, ex_rs, ex_rt, pc_write, mem_mem_read} !== {15'd0, 2'b11}) begin
         n_bad++; $display("FAIL lu_bubble: got ex=%0d/%b/%b/%0d/%0d pcw=%b mr=%b want all 0, pcw=1 mr=1", ex_alu_op, ex_reg_dest, ex_alu_src, ex_rs, ex_rt, pc_write, mem_mem_read); end
      tick();
      i_nop(); #1;
      n_cmp++; if ({ex_rs, fwd_a, fwd_b} !== {5'd2, 2'b01, 2'b00}) begin n_bad++; $display("FAIL lu_fwd: got rs=%0d a=%b b=%b want 2/01/00", ex_rs, fwd_a, fwd_b); end
      n_cmp++; if (obs_vec() !== exp_vec()) begin n_bad++; $display("FAIL lu_model: got %h want %h", obs_vec(), exp_vec()); end
      tick();
   endtask

   task automatic test_back_to_back();
      drain();
      i_add(5'd1, 5'd2, 5'd3); #1; tick();
      i_add(5'd5, 5'd1, 5'd1); #1; tick();
      i_nop(); #1;
      n_cmp++; if ({fwd_a, fwd_b} !== 4'b1010) begin n_bad++; $display("FAIL b2b_mem: got %b/%b want 10/10", fwd_a, fwd_b); end
      drain();
      i_add(5'd1, 5'd2, 5'd3); #1; tick();
      i_add(5'd6, 5'd7, 5'd7); #1; tick();
      i_add(5'd5, 5'd1, 5'd1); #1; tick();
      i_nop(); #1;
      n_cmp++; if ({fwd_a, fwd_b} !== 4'b0101) begin n_bad++; $display("FAIL b2b_wb: got %b/%b want 01/01", fwd_a, fwd_b); end
      tick();
   endtask

   task automatic test_double_hazard();
      drain();
      i_add(5'd3, 5'd1, 5'd2); #1; tick();
      i_add(5'd3, 5'd4, 5'd4); #1; tick();
      i_add(5'd8, 5'd3, 5'd0); #1; tick();
      i_nop(); #1;
      n_cmp++; if ({fwd_a, fwd_b} !== 4'b1000) begin n_bad++; $display("FAIL dbl_prio: got %b/%b want 10/00", fwd_a, fwd_b); end
      tick();
      i_add(5'd0, 5'd1, 5'd1); #1; tick();
      i_add(5'd0, 5'd2, 5'd2); #1; tick();
      i_add(5'd9, 5'd0, 5'd0); #1; tick();
      i_nop(); #1;
      n_cmp++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_bad++; $display("FAIL dbl_r0: got %b/%b want 00/00", fwd_a, fwd_b); end
      tick();
   endtask

   task automatic test_branch();
      drain();
      i_beq(5'd1, 5'd2); #1; tick();
      i_add(5'd4, 5'd5, 5'd6); ex_cond = 1'b1; #1;
      n_cmp++; if ({ifid_flush, pc_write, ifid_write} !== 3'b111) begin n_bad++; $display("FAIL br_taken: got %b want 111", {ifid_flush, pc_write, ifid_write}); end
      tick();
      ex_cond = 1'b0; i_nop(); #1;
      n_cmp++; if ({ex_alu_op, ex_reg_dest, ex_alu_src, ex_rs, ex_rt} !== 15'd0) begin n_bad++; $display("FAIL br_bubble: got %h want 0", {ex_alu_op, ex_reg_dest, ex_alu_src, ex_rs, ex_rt}); end
      tick();
      i_beq(5'd1, 5'd2); #1; tick();
      i_add(5'd4, 5'd5, 5'd6); #1;
      n_cmp++; if (ifid_flush !== 1'b0) begin n_bad++; $display("FAIL br_not_taken: got %b want 0", ifid_flush); end
      tick(); i_nop(); #1;
      n_cmp++; if ({ex_rs, ex_rt} !== {5'd5, 5'd6}) begin n_bad++; $display("FAIL br_fallthru: got %0d/%0d want 5/6", ex_rs, ex_rt); end
      tick();
   endtask

   task automatic test_taken_vs_stall();
      drain();
      set_id(3'd0, 0,1,1,1,0,1,1,0, 5'd0, 5'd2, 5'd0); #1; tick();
      i_add(5'd4, 5'd2, 5'd3); ex_cond = 1'b1; #1;
      n_cmp++; if ({pc_write, ifid_write, ifid_flush} !== 3'b111) begin n_bad++; $display("FAIL tvs_prio: got %b want 111", {pc_write, ifid_write, ifid_flush}); end
      tick();
      ex_cond = 1'b0; #1;
      n_cmp++; if ({ex_alu_op, ex_reg_dest, ex_alu_src, ex_rs, ex_rt} !== 15'd0) begin n_bad++; $display("FAIL tvs_bubble: got %h want 0", {ex_alu_op, ex_reg_dest, ex_alu_src, ex_rs, ex_rt}); end
      tick();
   endtask

   task automatic test_jump();
      drain();
      i_j(5'd0, 5'd5); #1;
      n_cmp++; if ({ifid_flush, pc_write} !== 2'b11) begin n_bad++; $display("FAIL j_flush: got %b want 11", {ifid_flush, pc_write}); end
      tick();
      i_add(5'd7, 5'd5, 5'd5); ex_cond = 1'b1; #1;
      n_cmp++; if ({ifid_flush, pc_write} !== 2'b01) begin n_bad++; $display("FAIL j_masked: got %b want 01", {ifid_flush, pc_write}); end
      tick();
      drain();
      i_lw(5'd2, 5'd0); #1; tick();
      i_j(5'd2, 5'd0); #1;
      n_cmp++; if ({pc_write, ifid_flush} !== 2'b00) begin n_bad++; $display("FAIL j_stall: got %b want 00", {pc_write, ifid_flush}); end
      tick(); #1;
      n_cmp++; if ({pc_write, ifid_flush} !== 2'b11) begin n_bad++; $display("FAIL j_retry: got %b want 11", {pc_write, ifid_flush}); end
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 79) == 0) begin
            rst = 1'b1;
            for (int i = 0; i < 3; i++) pipe[i] = nop_ins();
         end
         id_alu_op     = 3'($urandom);
         id_reg_dest   = 1'($urandom);
         id_reg_write  = 1'($urandom);
         id_alu_src    = 1'($urandom);
         id_mem_read   = ($urandom_range(0, 2) == 0);
         id_mem_write  = 1'($urandom);
         id_mem_to_reg = 1'($urandom);
         id_branch     = ($urandom_range(0, 3) == 0);
         id_jump       = ($urandom_range(0, 7) == 0);
         id_rs         = 5'($urandom_range(0, 3));
         id_rt         = 5'($urandom_range(0, 3));
         id_rd         = 5'($urandom_range(0, 3));
         ex_cond       = 1'($urandom);
         #1;
         n_cmp++; if (obs_vec() !== exp_vec()) begin n_bad++; $display("FAIL rand_cyc%0d: got %h want %h", c, obs_vec(), exp_vec()); end
         tick();
         rst = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1;
      ex_cond = 1'b0;
      i_nop();
      for (int i = 0; i < 3; i++) pipe[i] = nop_ins();
      test_reset();
      test_load_use();
      test_back_to_back();
      test_double_hazard();
      test_branch();
      test_taken_vs_stall();
      test_jump();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
